// File: rtl/subset_cmd_scheduler_if.sv
// Request, subset-broadcast and result signals of the subset command scheduler.
// master = surrounding logic (front-end, update agent, subsets); slave = scheduler.
interface subset_cmd_scheduler_if #(
    parameter int RULE_W = 11
);
    logic              srch_valid;
    logic              srch_ready;
    logic [103:0]      srch_tuple;
    logic              upd_valid;
    logic              upd_ready;
    logic [103:0]      upd_tuple;
    logic [1:0]        sub_command;
    logic [103:0]      sub_tupleData;
    logic [3:0]        sub_match;
    logic [RULE_W-1:0] sub_ruleID0;
    logic [RULE_W-1:0] sub_ruleID1;
    logic [RULE_W-1:0] sub_ruleID2;
    logic [RULE_W-1:0] sub_ruleID3;
    logic              res_valid;
    logic              res_match;
    logic [RULE_W-1:0] res_ruleID;
    logic [1:0]        res_subset;
    logic              upd_done;
    logic              busy;

    modport master (
        output srch_valid, srch_tuple, upd_valid, upd_tuple,
        output sub_match, sub_ruleID0, sub_ruleID1, sub_ruleID2, sub_ruleID3,
        input  srch_ready, upd_ready, sub_command, sub_tupleData,
        input  res_valid, res_match, res_ruleID, res_subset, upd_done, busy
    );

    modport slave (
        input  srch_valid, srch_tuple, upd_valid, upd_tuple,
        input  sub_match, sub_ruleID0, sub_ruleID1, sub_ruleID2, sub_ruleID3,
        output srch_ready, upd_ready, sub_command, sub_tupleData,
        output res_valid, res_match, res_ruleID, res_subset, upd_done, busy
    );
endinterface

// File: rtl/subset_cmd_scheduler.sv
// Arbitrates search/update requests, broadcasts one command at a time to the
// four subsets and resolves the subset match results to a single winning rule.
//   state  | meaning
//   IDLE   | accept a request (readies only here)
//   ISSUE  | command driven to the subsets for this one cycle
//   WAIT_S | counting search latency, sample subsets when count hits 0
//   WAIT_U | counting update latency
module subset_cmd_scheduler #(
    parameter int SEARCH_LAT = 3,
    parameter int UPDATE_LAT = 8,
    parameter int STARVE_MAX = 4,
    parameter int RULE_W     = 11
) (
    input logic                   clk,
    input logic                   rst,
    subset_cmd_scheduler_if.slave bus
);
    localparam int LAT_MAX = (SEARCH_LAT > UPDATE_LAT) ? SEARCH_LAT : UPDATE_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    localparam int STV_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] S_LOAD  = CNT_W'(SEARCH_LAT - 1);
    localparam logic [CNT_W-1:0] U_LOAD  = CNT_W'((UPDATE_LAT > 1) ? UPDATE_LAT - 2 : 0);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_S, WAIT_U} state_t;

    state_t            r_state;
    logic              r_is_search;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic [STV_W-1:0]  r_starve_cnt;
    logic [1:0]        r_sub_command;
    logic [103:0]      r_sub_tuple;
    logic              r_res_valid;
    logic              r_res_match;
    logic [RULE_W-1:0] r_res_ruleID;
    logic [1:0]        r_res_subset;
    logic              r_upd_done;

    logic              w_idle;
    logic              w_force_srch;
    logic              w_srch_grant;
    logic              w_upd_grant;
    logic              w_best_match;
    logic [RULE_W-1:0] w_best_id;
    logic [1:0]        w_best_idx;
    logic [RULE_W-1:0] w_ids [4];

    // Readies are gated by rst so a reset cycle never shows a handshake.
    assign w_idle       = (r_state == IDLE) && !rst;
    assign w_force_srch = (r_starve_cnt == STV_MAX);
    assign w_srch_grant = w_idle && bus.srch_valid && (!bus.upd_valid || w_force_srch);
    assign w_upd_grant  = w_idle && bus.upd_valid && !w_srch_grant;

    assign w_ids[0] = bus.sub_ruleID0;
    assign w_ids[1] = bus.sub_ruleID1;
    assign w_ids[2] = bus.sub_ruleID2;
    assign w_ids[3] = bus.sub_ruleID3;

    // Strict less-than keeps the lower subset index on equal rule IDs.
    always_comb begin
        w_best_match = 1'b0;
        w_best_id    = '0;
        w_best_idx   = 2'd0;
        for (int n = 0; n < 4; n++) begin
            if (bus.sub_match[n] && (!w_best_match || (w_ids[n] < w_best_id))) begin
                w_best_match = 1'b1;
                w_best_id    = w_ids[n];
                w_best_idx   = 2'(n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_is_search   <= 1'b0;
            r_lat_cnt     <= '0;
            r_starve_cnt  <= '0;
            r_sub_command <= 2'b00;
            r_sub_tuple   <= '0;
            r_res_valid   <= 1'b0;
            r_res_match   <= 1'b0;
            r_res_ruleID  <= '0;
            r_res_subset  <= 2'd0;
            r_upd_done    <= 1'b0;
        end else begin
            r_sub_command <= 2'b00;
            r_res_valid   <= 1'b0;
            r_upd_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_srch_grant) begin
                        r_sub_tuple   <= bus.srch_tuple;
                        r_sub_command <= 2'b10;
                        r_is_search   <= 1'b1;
                        r_starve_cnt  <= '0;
                        r_state       <= ISSUE;
                    end else if (w_upd_grant) begin
                        r_sub_tuple   <= bus.upd_tuple;
                        r_sub_command <= 2'b01;
                        r_is_search   <= 1'b0;
                        if (bus.srch_valid && !w_force_srch) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_is_search) begin
                        r_lat_cnt <= S_LOAD;
                        r_state   <= WAIT_S;
                    end else if (UPDATE_LAT == 1) begin
                        r_upd_done <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_lat_cnt <= U_LOAD;
                        r_state   <= WAIT_U;
                    end
                end
                WAIT_S: begin
                    if (r_lat_cnt == '0) begin
                        r_res_valid  <= 1'b1;
                        r_res_match  <= w_best_match;
                        r_res_ruleID <= w_best_id;
                        r_res_subset <= w_best_idx;
                        r_state      <= IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                WAIT_U: begin
                    if (r_lat_cnt == '0) begin
                        r_upd_done <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.srch_ready    = w_srch_grant;
    assign bus.upd_ready     = w_upd_grant;
    assign bus.sub_command   = r_sub_command;
    assign bus.sub_tupleData = r_sub_tuple;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_match     = r_res_match;
    assign bus.res_ruleID    = r_res_ruleID;
    assign bus.res_subset    = r_res_subset;
    assign bus.upd_done      = r_upd_done;
    assign bus.busy          = (r_state != IDLE);
endmodule

// File: tb/tb_subset_cmd_scheduler.sv
// Directed + randomized bench for subset_cmd_scheduler, checked against a
// transaction-level model of arbitration, timing and rule resolution.
module tb_subset_cmd_scheduler;
    localparam int SL = 3;
    localparam int UL = 8;
    localparam int SM = 4;
    localparam int RW = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    subset_cmd_scheduler_if #(.RULE_W(RW)) bus ();

    subset_cmd_scheduler #(
        .SEARCH_LAT(SL), .UPDATE_LAT(UL), .STARVE_MAX(SM), .RULE_W(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int starve  = 0;
    logic [103:0]  last_tuple = '0;
    logic [RW+2:0] last_res   = '0;
    logic          ready_log[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [103:0] rand_tuple();
        return 104'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    // Result as {match, ruleID, subset}: smallest (id, index) pair among matches.
    function automatic logic [RW+2:0] resolve(input logic [3:0] m, input logic [RW-1:0] ids [4]);
        logic [RW+1:0] best;
        bit            any;
        best = '1;
        any  = 0;
        for (int n = 0; n < 4; n++) begin
            if (m[n]) begin
                any = 1;
                if ({ids[n], 2'(n)} < best) best = {ids[n], 2'(n)};
            end
        end
        return any ? {1'b1, best} : '0;
    endfunction

    task automatic drive_sub(input logic [3:0] m, input logic [RW-1:0] ids [4]);
        bus.sub_match   = m;
        bus.sub_ruleID0 = ids[0];
        bus.sub_ruleID1 = ids[1];
        bus.sub_ruleID2 = ids[2];
        bus.sub_ruleID3 = ids[3];
    endtask

    task automatic drive_junk();
        bus.sub_match   = 4'($urandom);
        bus.sub_ruleID0 = RW'($urandom);
        bus.sub_ruleID1 = RW'($urandom);
        bus.sub_ruleID2 = RW'($urandom);
        bus.sub_ruleID3 = RW'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd"},   128'(bus.sub_command),   128'(0));
        check({tag, "_tuple"}, 128'(bus.sub_tupleData), 128'(0));
        check({tag, "_res"},   128'({bus.res_valid, bus.res_match, bus.res_ruleID, bus.res_subset}), 128'(0));
        check({tag, "_done"},  128'(bus.upd_done),      128'(0));
        check({tag, "_busy"},  128'(bus.busy),          128'(0));
        check({tag, "_rdy"},   128'({bus.srch_ready, bus.upd_ready}), 128'(0));
    endtask

    // Runs one operation starting in the current (idle) cycle; returns in the
    // completion cycle so the caller may start the next one back-to-back.
    task automatic do_op(input bit sv, input bit uv, input logic [103:0] ts, input logic [103:0] tu,
                         input logic [3:0] m, input logic [RW-1:0] ids [4], input bit hold);
        bit            gs;
        logic [103:0]  tup;
        logic [RW+2:0] exp_res;
        bus.srch_valid = sv;
        bus.upd_valid  = uv;
        bus.srch_tuple = ts;
        bus.upd_tuple  = tu;
        gs  = sv && (!uv || starve == SM);
        tup = gs ? ts : tu;
        #1;
        check("srch_ready", 128'(bus.srch_ready), 128'(gs));
        check("upd_ready", 128'(bus.upd_ready), 128'(!gs));
        check("tuple_hold", 128'(bus.sub_tupleData), 128'(last_tuple));
        ready_log.push_back(bus.srch_ready);
        if (gs) starve = 0;
        else if (sv && starve < SM) starve++;

        step();
        if (!hold) begin
            bus.srch_valid = 1'b0;
            bus.upd_valid  = 1'b0;
        end
        #1;
        check("cmd_issue", 128'(bus.sub_command), 128'(gs ? 2'b10 : 2'b01));
        check("tuple_issue", 128'(bus.sub_tupleData), 128'(tup));
        check("busy_issue", 128'(bus.busy), 128'(1));
        check("pulses_issue", 128'({bus.res_valid, bus.upd_done}), 128'(0));
        check("rdy_issue", 128'({bus.srch_ready, bus.upd_ready}), 128'(0));
        last_tuple = tup;

        if (gs) begin
            exp_res = resolve(m, ids);
            for (int k = 1; k <= SL; k++) begin
                step();
                if (k == SL) drive_sub(m, ids);
                else drive_junk();
                #1;
                check("cmd_wait_s", 128'(bus.sub_command), 128'(0));
                check("resv_wait", 128'(bus.res_valid), 128'(0));
                check("busy_wait_s", 128'(bus.busy), 128'(1));
                check("rdy_wait_s", 128'({bus.srch_ready, bus.upd_ready}), 128'(0));
            end
            step();
            drive_junk();
            #1;
            check("res_valid", 128'(bus.res_valid), 128'(1));
            check("res_match", 128'(bus.res_match), 128'(exp_res[RW+2]));
            check("res_ruleID", 128'(bus.res_ruleID), 128'(exp_res[RW+1:2]));
            check("res_subset", 128'(bus.res_subset), 128'(exp_res[1:0]));
            check("busy_done_s", 128'(bus.busy), 128'(0));
            last_res = exp_res;
        end else begin
            for (int k = 1; k < UL; k++) begin
                step();
                drive_junk();
                #1;
                check("cmd_wait_u", 128'(bus.sub_command), 128'(0));
                check("done_wait", 128'(bus.upd_done), 128'(0));
                check("busy_wait_u", 128'(bus.busy), 128'(1));
                check("rdy_wait_u", 128'({bus.srch_ready, bus.upd_ready}), 128'(0));
            end
            step();
            #1;
            check("upd_done", 128'(bus.upd_done), 128'(1));
            check("busy_done_u", 128'(bus.busy), 128'(0));
            check("resv_upd", 128'(bus.res_valid), 128'(0));
            check("res_hold", 128'({bus.res_match, bus.res_ruleID, bus.res_subset}), 128'(last_res));
        end
    endtask

    task automatic gap_cycle();
        step();
        #1;
        check("gap_quiet", 128'({bus.res_valid, bus.upd_done, bus.busy, bus.sub_command}), 128'(0));
    endtask

    initial begin
        logic [RW-1:0] ids [4];
        logic [9:0]    order;
        int            sel;

        rst = 1'b1;
        bus.srch_valid = 1'b0;
        bus.upd_valid  = 1'b0;
        bus.srch_tuple = '0;
        bus.upd_tuple  = '0;
        drive_junk();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        gap_cycle();

        // Single search: subsets 1 and 2 match, ID 12 wins.
        ids[0] = RW'(0); ids[1] = RW'(37); ids[2] = RW'(12); ids[3] = RW'(0);
        do_op(1, 0, 104'h1, rand_tuple(), 4'b0110, ids, 0);
        gap_cycle();

        // Tie between subsets 0 and 3, then no match at all.
        ids[0] = RW'(5); ids[1] = RW'(2); ids[2] = RW'(1); ids[3] = RW'(5);
        do_op(1, 0, rand_tuple(), rand_tuple(), 4'b1001, ids, 0);
        gap_cycle();
        do_op(1, 0, rand_tuple(), rand_tuple(), 4'b0000, ids, 0);
        gap_cycle();

        // Update timing.
        do_op(0, 1, rand_tuple(), rand_tuple(), 4'b0000, ids, 0);
        gap_cycle();

        // Starvation: both channels held valid through ten grants.
        ready_log.delete();
        for (int i = 0; i < 10; i++) begin
            for (int n = 0; n < 4; n++) ids[n] = RW'($urandom);
            do_op(1, 1, rand_tuple(), rand_tuple(), 4'($urandom), ids, 1);
        end
        order = '0;
        for (int i = 0; i < 10; i++) order[i] = ready_log[i];
        check("grant_order", 128'(order), 128'(10'b10000_10000));
        bus.srch_valid = 1'b0;
        bus.upd_valid  = 1'b0;
        gap_cycle();

        // Reset one cycle after the search command.
        bus.srch_valid = 1'b1;
        bus.srch_tuple = rand_tuple();
        #1;
        check("rst_hs", 128'(bus.srch_ready), 128'(1));
        step();
        bus.srch_valid = 1'b0;
        #1;
        check("rst_cmd", 128'(bus.sub_command), 128'(2'b10));
        step();
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        starve = 0;
        last_tuple = '0;
        last_res = '0;
        for (int i = 0; i < SL + 2; i++) begin
            step();
            #1;
            check("rst_no_res", 128'({bus.res_valid, bus.busy}), 128'(0));
        end
        for (int n = 0; n < 4; n++) ids[n] = RW'($urandom_range(0, 3));
        do_op(1, 0, rand_tuple(), rand_tuple(), 4'b1111, ids, 0);

        // Back-to-back searches: next handshake in the res_valid cycle.
        for (int n = 0; n < 4; n++) ids[n] = RW'($urandom);
        do_op(1, 0, rand_tuple(), rand_tuple(), 4'b1010, ids, 0);
        do_op(1, 0, rand_tuple(), rand_tuple(), 4'b0101, ids, 0);
        gap_cycle();

        // Randomized mix of operations, contention and gaps.
        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 2));
            for (int n = 0; n < 4; n++)
                ids[n] = $urandom_range(0, 1) ? RW'($urandom_range(0, 3)) : RW'($urandom);
            do_op(sel != 1, sel != 0, rand_tuple(), rand_tuple(), 4'($urandom), ids, 0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) gap_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/subset_cmd_scheduler.md
Name: subset_cmd_scheduler

Overview:
- Sequences the four classification subsets. Accepts search requests and rule-update requests on two valid/ready channels.
- Arbitrates between the two channels and issues one command at a time to all subsets: 2'b10 for search, 2'b01 for update, 2'b00 for idle.
- For a search, it waits the fixed subset latency, then resolves the four subset match results to a single winning rule.
- Sits between the packet front-end / update agent and the subset0..subset3 array.

Parameters:
- SEARCH_LAT, 3: cycles from the command cycle to the cycle in which sub_match/sub_ruleIDn are valid. Minimum 1.
- UPDATE_LAT, 8: cycles an update occupies the subsets. Minimum 1.
- STARVE_MAX, 4: consecutive search losses tolerated before a search is forced to win. Minimum 1.
- RULE_W, 11: rule ID width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- srch_valid  in  1  search request present.
- srch_ready  out  1  search accepted this cycle (combinational).
- srch_tuple  in  104  search tuple. Bit fields: srcIP 0-31, dstIP 32-63, srcport 64-79, dstport 80-95, protocol 96-103.
- upd_valid  in  1  update request present.
- upd_ready  out  1  update accepted this cycle (combinational).
- upd_tuple  in  104  update rule data; same bit fields as srch_tuple.
- sub_command  out  2  command broadcast to the subsets.
- sub_tupleData  out  104  tuple broadcast to the subsets.
- sub_match  in  4  per-subset match flag; bit n belongs to subset n.
- sub_ruleID0..sub_ruleID3  in  RULE_W each  per-subset matched rule ID.
- res_valid  out  1  one-cycle pulse: search result valid.
- res_match  out  1  at least one subset matched.
- res_ruleID  out  RULE_W  winning rule ID.
- res_subset  out  2  index of the winning subset.
- upd_done  out  1  one-cycle pulse: update complete.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; sub_command 2'b00; sub_tupleData 0; state IDLE; starve_cnt 0; latency counter 0.
- States:
  - IDLE: accept a request.
  - ISSUE: drive the command.
  - WAIT_S: count search latency.
  - WAIT_U: count update latency.
- Arbitration (IDLE only; the readies are 0 in every other state):
  - Only one channel valid: that channel is granted.
  - Both valid: update wins, unless starve_cnt == STARVE_MAX, in which case search wins.
  - Exactly one ready is high in a grant cycle. A handshake is valid && ready.
- starve_cnt:
  - Increments when search is valid but loses.
  - Clears on a search grant.
  - Saturates at STARVE_MAX.
- Handshake in cycle T: the granted tuple is registered into sub_tupleData; next state is ISSUE.
- ISSUE, cycle C = T+1:
  - sub_command = 2'b10 (search) or 2'b01 (update) for exactly this one cycle; 2'b00 in every other cycle.
  - sub_tupleData holds its value until the next grant.
- Search completion:
  - WAIT_S counts so that sub_match and sub_ruleIDn are sampled on the edge ending cycle C+SEARCH_LAT.
  - res_* are registered and res_valid = 1 in cycle C+SEARCH_LAT+1 only.
  - The state is IDLE in that same cycle, so a new handshake may occur there.
  - With SEARCH_LAT = 1, the sample cycle is C+1.
- Resolution:
  - Among subsets with sub_match[n] = 1, the smallest ruleID wins.
  - Equal IDs: the lowest subset index wins.
  - No match: res_match = 0, res_ruleID = 0, res_subset = 0.
  - res_* hold their values until the next res_valid.
- Update completion:
  - upd_done = 1 in cycle C+UPDATE_LAT.
  - The state is IDLE in cycle C+UPDATE_LAT, so a handshake is allowed there.
- sub_match and sub_ruleIDn are ignored outside the sample cycle.
- Only one operation is in flight at a time; no pipelining of searches.
- Reset mid-operation:
  - The in-flight op is dropped; no res_valid or upd_done is produced for it.
  - All state returns to reset values on the next edge.
  - Reset has priority over any handshake in the same cycle.
- Tuple widths are fixed at 104 bits.
- The comparison of RULE_W-bit IDs is unsigned.

Test Plan:
1. Single search, no contention:
   - Stimulus: srch_valid with tuple 104'h1, handshake at T; subsets return sub_match = 4'b0110, ID1 = 37, ID2 = 12 at C+3.
   - Required: sub_command = 10 only at T+1; res_valid at T+5 with res_match = 1, res_ruleID = 12, res_subset = 2.
2. Tie and no-match:
   - Stimulus: sub_match = 4'b1001 with ID0 = ID3 = 5. Then a second search with sub_match = 0.
   - Required: first result res_ruleID = 5, res_subset = 0. Second result res_match = 0, res_ruleID = 0.
3. Update timing:
   - Stimulus: upd handshake at T.
   - Required: sub_command = 01 at T+1; busy high T+1..T+8; upd_done pulse at T+9; srch_ready = 0 throughout.
4. Starvation:
   - Stimulus: upd_valid and srch_valid held high continuously, STARVE_MAX = 4.
   - Required: grant order U,U,U,U,S,U,U,U,U,S; starve_cnt is 0 after each S.
5. Reset mid-search:
   - Stimulus: rst asserted at C+1 for one cycle.
   - Required: no res_valid; all outputs 0 the next cycle; a subsequent search completes normally.
6. Back-to-back:
   - Stimulus: a search handshake occurs in the res_valid cycle of the previous search.
   - Required: the new sub_command = 10 appears exactly one cycle later; sub_tupleData updates in the handshake cycle+1.
